// File: rtl/reg_file_seq_pkg.sv
// Shared constants for the register-file sequencer: instruction field positions,
// opcodes, FSM state encodings, FunSel codes and select/enable encodings.
package reg_file_seq_pkg;

   // Instruction word layout
   localparam int unsigned InstrW  = 16;
   localparam int unsigned OpMsb   = 15;
   localparam int unsigned OpLsb   = 12;
   localparam int unsigned DstMsb  = 11;
   localparam int unsigned DstLsb  = 9;
   localparam int unsigned Src1Msb = 8;
   localparam int unsigned Src1Lsb = 6;
   localparam int unsigned Src2Msb = 5;
   localparam int unsigned Src2Lsb = 3;

   // Opcodes; anything above OpAdd is illegal
   localparam logic [3:0] OpNop = 4'd0;
   localparam logic [3:0] OpInc = 4'd1;
   localparam logic [3:0] OpDec = 4'd2;
   localparam logic [3:0] OpClr = 4'd3;
   localparam logic [3:0] OpMov = 4'd4;
   localparam logic [3:0] OpAdd = 4'd5;

   // FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t StIdle  = 2'd0;
   localparam state_t StRead  = 2'd1;
   localparam state_t StWrite = 2'd2;
   localparam state_t StDone  = 2'd3;

   // Register function codes
   localparam logic [2:0] FunDec  = 3'b000;
   localparam logic [2:0] FunInc  = 3'b001;
   localparam logic [2:0] FunLoad = 3'b010;
   localparam logic [2:0] FunClr  = 3'b011;

   // Read selects: 0-3 = R1-R4, 4-7 = S1-S4; enables are active low
   localparam logic [2:0] SelIdle = 3'b000;
   localparam logic [3:0] EnNone  = 4'b1111;

   function automatic logic op_is_illegal(input logic [3:0] op);
      return op > OpAdd;
   endfunction

endpackage

// File: rtl/reg_file_sequencer_if.sv
// Instruction handshake plus register-file control bundle.
interface reg_file_sequencer_if;
   import reg_file_seq_pkg::*;

   logic              InstrValid;
   logic [InstrW-1:0] Instr;
   logic              InstrReady;
   logic              Busy;
   logic              Done;
   logic              Err;
   logic [2:0]        OutASel;
   logic [2:0]        OutBSel;
   logic [2:0]        FunSel;
   logic [3:0]        RegSel;
   logic [3:0]        ScrSel;

   modport master (
      output InstrValid, Instr,
      input  InstrReady, Busy, Done, Err, OutASel, OutBSel, FunSel, RegSel, ScrSel
   );

   modport slave (
      input  InstrValid, Instr,
      output InstrReady, Busy, Done, Err, OutASel, OutBSel, FunSel, RegSel, ScrSel
   );

endinterface

// File: rtl/rf_enable_decode.sv
// Turns a 3-bit destination and a write strobe into the active-low RegSel/ScrSel
// enables. Dst 0-3 targets R1-R4, Dst 4-7 targets S1-S4; bit3 is R1/S1.
module rf_enable_decode
   import reg_file_seq_pkg::*;
(
   input  logic [2:0] dst,
   input  logic       wr_en,
   output logic [3:0] reg_sel,
   output logic [3:0] scr_sel
);

   // One enable low for the selected bank; ~dst[1:0] maps Dst 0/4 to bit 3
   always_comb begin
      reg_sel = EnNone;
      scr_sel = EnNone;
      if (wr_en) begin
         if (!dst[2]) begin
            reg_sel[~dst[1:0]] = 1'b0;
         end else begin
            scr_sel[~dst[1:0]] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_file_sequencer.sv
// Register-file sequencer. Accepts one instruction at a time in IDLE, latches it
// into IR, then walks READ/WRITE/DONE as the opcode needs, driving the register
// file read selects, function code and write enables. Outputs are decoded from
// the state register and IR only, except that Reset masks the write enables
// combinationally so a write in flight never lands on the reset edge.
module reg_file_sequencer
   import reg_file_seq_pkg::*;
(
   input  logic                 Clock,
   input  logic                 Reset,
   reg_file_sequencer_if.slave  bus
);

   state_t            state_q, state_d;
   logic [InstrW-1:0] ir_q;
   logic              accept;
   logic [3:0]        in_op;
   logic [3:0]        ir_op;
   logic [2:0]        ir_dst;
   logic [2:0]        ir_src1;
   logic [2:0]        ir_src2;
   logic              wr_strobe;
   logic [3:0]        reg_sel;
   logic [3:0]        scr_sel;

   assign in_op   = bus.Instr[OpMsb:OpLsb];
   assign ir_op   = ir_q[OpMsb:OpLsb];
   assign ir_dst  = ir_q[DstMsb:DstLsb];
   assign ir_src1 = ir_q[Src1Msb:Src1Lsb];
   assign ir_src2 = ir_q[Src2Msb:Src2Lsb];

   // Handshake only completes in IDLE; valid elsewhere is simply ignored
   assign accept = (state_q == StIdle) && bus.InstrValid;

   // Next-state: opcode class picks the entry state, the rest is a fixed walk
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_op == OpInc || in_op == OpDec || in_op == OpClr) begin
                  state_d = StWrite;
               end else if (in_op == OpMov || in_op == OpAdd) begin
                  state_d = StRead;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRead:  state_d = StWrite;
         StWrite: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and IR registers with synchronous reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ir_q <= bus.Instr;
         end
      end
   end

   // Write strobe: WRITE with a writing opcode, masked by Reset
   assign wr_strobe = (state_q == StWrite) && !Reset && !op_is_illegal(ir_op) &&
                      (ir_op != OpNop);

   rf_enable_decode u_enable_decode (
      .dst     (ir_dst),
      .wr_en   (wr_strobe),
      .reg_sel (reg_sel),
      .scr_sel (scr_sel)
   );

   assign bus.RegSel = reg_sel;
   assign bus.ScrSel = scr_sel;

   // Moore status and datapath control decoded from state and IR
   always_comb begin
      bus.InstrReady = (state_q == StIdle);
      bus.Busy       = (state_q != StIdle);
      bus.Done       = (state_q == StDone);
      bus.Err        = (state_q == StDone) && op_is_illegal(ir_op);
      bus.OutASel    = SelIdle;
      bus.OutBSel    = SelIdle;
      bus.FunSel     = FunLoad;
      // Selects stay put across READ and WRITE so the external ALU settles
      if (state_q == StRead || state_q == StWrite) begin
         bus.OutASel = ir_src1;
         bus.OutBSel = ir_src2;
      end
      if (state_q == StWrite) begin
         unique case (ir_op)
            OpInc:   bus.FunSel = FunInc;
            OpDec:   bus.FunSel = FunDec;
            OpClr:   bus.FunSel = FunClr;
            default: bus.FunSel = FunLoad;
         endcase
      end
   end

   // At most one write enable may be low at any time
   assert property (@(posedge Clock) $countones(~{reg_sel, scr_sel}) <= 1);
   // Illegal opcodes never write
   assert property (@(posedge Clock)
      op_is_illegal(ir_op) |-> ({reg_sel, scr_sel} == {EnNone, EnNone}));

endmodule
